// File: rtl/hex_disp_pkg.sv
// Shared types and helpers for the seven-segment scrolling display path.
package hex_disp_pkg;

  localparam int unsigned CODE_W = 4;
  localparam logic [CODE_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // (pos + ofs) mod len; valid for pos < len and ofs < len, no divider needed
  function automatic int unsigned mod_index(input int unsigned pos,
                                            input int unsigned ofs,
                                            input int unsigned len);
    int unsigned s;
    s = pos + ofs;
    return (s >= len) ? (s - len) : s;
  endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Programmable divider producing a one-cycle tick every TICK_DIV enabled cycles.
module scroll_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == LAST);

  // clr wins over en so a restart always begins a full period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a circular buffer of 4-bit character codes across NUM_DIGITS display digits.
module hex_scroll_ctrl
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned TICK_DIV   = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [CODE_W*MSG_LEN-1:0]    msg_in,
  input  logic                         start,
  input  logic                         stop,
  output logic                         busy,
  output logic                         wrap,
  output logic [CODE_W*NUM_DIGITS-1:0] digit_codes
);

  localparam int unsigned POS_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(MSG_LEN - 1);

  state_e state, state_nxt;
  logic [MSG_LEN-1:0][CODE_W-1:0] buffer;
  logic [POS_W-1:0]               pos;
  logic tick_c, cnt_en_c, cnt_clr_c, capture_c, pos_clr_c;

  scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (cnt_en_c),
    .clr    (cnt_clr_c),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // stop outranks start in every state; IDLE keeps the divider cleared
  always_comb begin
    state_nxt = state;
    cnt_en_c  = 1'b0;
    cnt_clr_c = 1'b0;
    capture_c = 1'b0;
    pos_clr_c = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr_c = 1'b1;
        capture_c = load;
        if (start && !stop) state_nxt = RUN;
      end
      RUN: begin
        cnt_en_c = 1'b1;
        if (stop) state_nxt = HOLD;
      end
      HOLD: begin
        if (stop) begin
          state_nxt = IDLE;
          cnt_clr_c = 1'b1;
          pos_clr_c = 1'b1;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= {MSG_LEN{BLANK_CODE}};
      pos    <= '0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      wrap <= tick_c && (pos == LAST_POS);
      if (capture_c) buffer <= msg_in;
      if (capture_c || pos_clr_c) pos <= '0;
      else if (tick_c)            pos <= (pos == LAST_POS) ? '0 : pos + POS_W'(1);
    end
  end

  // leftmost digit (i=0) occupies the top nibble
  always_comb begin
    digit_codes = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      digit_codes[CODE_W*(NUM_DIGITS-1-i) +: CODE_W] =
        buffer[POS_W'(mod_index(32'(pos), i, MSG_LEN))];
    end
  end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Randomized and directed bench for hex_scroll_ctrl against a behavioural scroll model.
module tb_hex_scroll_ctrl;

  localparam int unsigned ND   = 4;
  localparam int unsigned LA   = 6;
  localparam int unsigned TDA  = 3;
  localparam int unsigned LB   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic            load_a = 0, start_a = 0, stop_a = 0;
  logic [4*LA-1:0] msg_a = '0;
  logic            busy_a, wrap_a;
  logic [4*ND-1:0] codes_a;

  logic            load_b = 0, start_b = 0, stop_b = 0;
  logic [4*LB-1:0] msg_b = '0;
  logic            busy_b, wrap_b;
  logic [4*ND-1:0] codes_b;

  int total = 0;
  int bad   = 0;

  // behavioural model of instance A: 0=idle 1=run 2=hold
  int         m_state, m_pos, m_cnt;
  logic       m_wrap;
  logic [3:0] m_buf [LA];

  always #5 clk = ~clk;

  hex_scroll_ctrl #(.NUM_DIGITS(ND), .MSG_LEN(LA), .TICK_DIV(TDA)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .msg_in(msg_a), .start(start_a),
    .stop(stop_a), .busy(busy_a), .wrap(wrap_a), .digit_codes(codes_a)
  );

  hex_scroll_ctrl #(.NUM_DIGITS(ND), .MSG_LEN(LB), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load_b), .msg_in(msg_b), .start(start_b),
    .stop(stop_b), .busy(busy_b), .wrap(wrap_b), .digit_codes(codes_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_cnt = 0; m_wrap = 1'b0;
    for (int i = 0; i < LA; i++) m_buf[i] = 4'hF;
  endtask

  function automatic logic [15:0] model_codes();
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) r = {r[11:0], m_buf[(m_pos + i) % LA]};
    return r;
  endfunction

  task automatic model_step(input logic ld, input logic st, input logic sp,
                            input logic [4*LA-1:0] msg);
    m_wrap = 1'b0;
    case (m_state)
      0: begin
        if (ld) begin
          for (int i = 0; i < LA; i++) m_buf[i] = msg[4*i +: 4];
          m_pos = 0;
        end
        if (st && !sp) begin m_state = 1; m_cnt = 0; end
      end
      1: begin
        m_cnt = m_cnt + 1;
        if (m_cnt == TDA) begin
          m_cnt = 0;
          m_wrap = (m_pos == LA - 1);
          m_pos = (m_pos + 1) % LA;
        end
        if (sp) m_state = 2;
      end
      default: begin
        if (sp) begin m_state = 0; m_pos = 0; m_cnt = 0; end
        else if (st) m_state = 1;
      end
    endcase
  endtask

  task automatic compare_a();
    check("busy_a", 32'(busy_a), 32'(m_state != 0));
    check("wrap_a", 32'(wrap_a), 32'(m_wrap));
    check("codes_a", 32'(codes_a), 32'(model_codes()));
  endtask

  // one clock for instance A: sample inputs into the model at the edge, compare after it
  task automatic tick_a();
    @(posedge clk);
    model_step(load_a, start_a, stop_a, msg_a);
    #1;
    compare_a();
    load_a = 0; start_a = 0; stop_a = 0;
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
    load_b = 0; start_b = 0; stop_b = 0;
  endtask

  initial begin
    logic [15:0] exp_b;
    int p;
    model_reset();
    #12 rst_n = 1'b1;
    tick_a();
    check("reset_codes", 32'(codes_a), 32'h0000FFFF);

    // load and first scroll lap
    msg_a = 24'hEDCBA9; load_a = 1; tick_a();
    check("load_codes", 32'(codes_a), 32'h00009ABC);
    start_a = 1; tick_a();
    for (int k = 1; k <= 18; k++) begin
      tick_a();
      if (k == 3)  check("step1", 32'(codes_a), 32'h0000ABCD);
      if (k == 6)  check("step2", 32'(codes_a), 32'h0000BCDE);
      if (k == 18) begin
        check("lap_codes", 32'(codes_a), 32'h00009ABC);
        check("lap_wrap", 32'(wrap_a), 32'h1);
      end
    end

    // hold one cycle into a step, resume, then stop twice back to idle
    stop_a = 1; tick_a();
    for (int k = 0; k < 10; k++) tick_a();
    check("hold_frozen", 32'(codes_a), 32'h00009ABC);
    start_a = 1; tick_a();
    tick_a();
    check("resume_early", 32'(codes_a), 32'h00009ABC);
    tick_a();
    check("resume_step", 32'(codes_a), 32'h0000ABCD);
    stop_a = 1; tick_a();
    stop_a = 1; tick_a();
    check("hold_stop_codes", 32'(codes_a), 32'h00009ABC);
    check("hold_stop_busy", 32'(busy_a), 32'h0);

    // priority: start+stop in RUN, load during RUN ignored
    start_a = 1; tick_a();
    start_a = 1; stop_a = 1; tick_a();
    check("prio_busy", 32'(busy_a), 32'h1);
    start_a = 1; tick_a();
    msg_a = 24'h123456; load_a = 1; tick_a();
    for (int k = 0; k < 8; k++) tick_a();

    // randomized pulses
    for (int k = 0; k < 400; k++) begin
      load_a  = ($urandom_range(0, 9) == 0);
      start_a = ($urandom_range(0, 6) == 0);
      stop_a  = ($urandom_range(0, 9) == 0);
      msg_a   = 24'($urandom);
      tick_a();
    end

    // asynchronous reset mid-run
    stop_a = 1; tick_a();
    stop_a = 1; tick_a();
    start_a = 1; tick_a();
    msg_a = 24'h654321; tick_a();
    tick_a(); tick_a();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_a), 32'h0);
    check("arst_wrap", 32'(wrap_a), 32'h0);
    check("arst_codes", 32'(codes_a), 32'h0000FFFF);
    model_reset();
    #10 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick_a();
    check("post_rst_codes", 32'(codes_a), 32'h0000FFFF);

    // instance B: TICK_DIV=1, MSG_LEN=5; chars 0..4 are 1..5
    msg_b = 20'h54321; load_b = 1; tick_b();
    check("b_load", 32'(codes_b), 32'h00001234);
    start_b = 1; tick_b();
    check("b_pos0", 32'(codes_b), 32'h00001234);
    for (int k = 1; k <= 11; k++) begin
      tick_b();
      p = k % LB;
      exp_b = '0;
      for (int i = 0; i < ND; i++) exp_b = {exp_b[11:0], 4'(((p + i) % LB) + 1)};
      check("b_codes", 32'(codes_b), 32'(exp_b));
      check("b_wrap", 32'(wrap_b), 32'(p == 0));
      check("b_busy", 32'(busy_b), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_scroll_ctrl.md
Name: hex_scroll_ctrl

Overview:
Sequencer that scrolls a stored message of 4-bit character codes across a row of seven-segment digits.
Holds a message buffer and a scroll position, and advances the position on a programmable tick.
Presents one 4-bit code per digit to the team's existing per-digit hex/character decoders, in which code 4'hF = blank.
Sits between switch/key input logic and the display decoders.

Parameters:
NUM_DIGITS, 4, number of physical digits driven (window width)
MSG_LEN, 8, characters in message buffer; legal range MSG_LEN >= NUM_DIGITS
TICK_DIV, 50_000_000, clock cycles per scroll step; legal range >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  one-cycle request to capture msg_in; accepted only in IDLE
msg_in  in  4*MSG_LEN  message; msg_in[3:0] = character 0
start  in  1  one-cycle request: begin scrolling (IDLE) or resume (HOLD)
stop  in  1  one-cycle request: pause (RUN) or return to start (HOLD)
busy  out  1  high when state != IDLE
wrap  out  1  one-cycle pulse when position wraps from MSG_LEN-1 to 0
digit_codes  out  4*NUM_DIGITS  codes for decoders; top nibble = leftmost digit

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE; buffer all 4'hF; pos=0; tick counter=0; busy=0; wrap=0; digit_codes all 4'hF.
- States and transitions:
  - IDLE: load -> buffer<=msg_in, pos<=0. Start -> RUN with counter=0.
  - RUN: counter increments every cycle. At count TICK_DIV-1: counter<=0 and pos<=(pos+1) mod MSG_LEN. Stop -> HOLD.
  - HOLD: pos and counter frozen. Start -> RUN, counter resumes from its frozen value. Stop -> IDLE with pos<=0 and counter<=0.
- Priority and ignored requests:
  - stop beats start in the same cycle.
  - load outside IDLE is ignored; the buffer is unchanged.
  - load and start together in IDLE: both take effect on the same edge, so RUN begins on the new message at pos 0.
  - start in RUN and stop in IDLE are ignored.
- Window:
  - Digit i (i=0 leftmost) shows buffer[(pos+i) mod MSG_LEN], which is circular, with no blank padding.
  - digit_codes is a combinational function of the registered buffer and pos. It reflects a load or step in the cycle after the capturing edge.
- Step timing: the first step occurs TICK_DIV cycles after entering RUN from IDLE. With TICK_DIV=1, pos advances every RUN cycle.
- wrap: registered; high for exactly the one cycle following the edge on which pos goes MSG_LEN-1 -> 0. Never asserted in IDLE or HOLD, and not asserted by the stop-from-HOLD reset of pos.
- Width rules:
  - pos width = clog2(MSG_LEN), minimum 1.
  - counter width = clog2(TICK_DIV), minimum 1.
  - Modular addition must be correct when MSG_LEN is not a power of two; never rely on natural overflow.
- Reset mid-scroll: immediate return to the reset values above, including clearing the buffer to blank.

Decomposition:
- Package hex_disp_pkg:
  - BLANK_CODE = 4'hF.
  - State enum {IDLE, RUN, HOLD}.
  - Helper function for the modular index (pos+i) mod MSG_LEN.
- One sub-module: scroll_tick_gen.
  - Parameterised by TICK_DIV.
  - Inputs: en and clr.
  - Output: one-cycle tick at terminal count.
  - Counter held when en=0.

Test Plan:
- Run all scenarios with NUM_DIGITS=4, MSG_LEN=6, TICK_DIV=3 unless stated.
- Reset: assert rst_n=0 mid-RUN -> busy=0, wrap=0, digit_codes=16'hFFFF asynchronously; stays so after release until load.
- Load: load msg_in=24'hEDCBA9 in IDLE -> next cycle digit_codes=16'h9ABC, busy=0.
- Scroll and wrap: start -> digit_codes 16'hABCD after 3 cycles, 16'hBCDE after 6. After 18 cycles back to 16'h9ABC, with wrap high for exactly that one cycle.
- Hold and resume: stop 1 cycle into a step -> digit_codes frozen for 10 cycles. Start -> next step exactly 2 cycles later. Second stop in HOLD -> IDLE, digit_codes=16'h9ABC.
- Priority: start and stop in the same RUN cycle -> HOLD. load during RUN -> buffer unchanged, scrolling continues.
- TICK_DIV=1 with MSG_LEN=5 (non-power-of-two) -> pos sequence 0,1,2,3,4,0 on consecutive cycles; wrap every 5th cycle.
